// File: rtl/pow5_sched_pkg.sv
// Shared definitions for the pow5 scheduler: FSM encoding and parameter defaults.
package pow5_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 18;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/pow5_rr_pick.sv
// Combinational round-robin selector: first set req bit searching upward
// from last+1, wrapping at N_REQ. pick is one-hot (all zero when !any).
module pow5_rr_pick #(
    parameter int N_REQ = 4,
    parameter int LW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [LW-1:0]    last,
    output logic             any,
    output logic [N_REQ-1:0] pick
);

    int          idx;
    logic [LW-1:0] sel;
    logic        found;

    // Walk the N_REQ positions after last; the first requesting one wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            sel = LW'(idx);
            if (!found && req[sel]) begin
                pick[sel] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/pow5_sched.sv
// Round-robin scheduler sharing one multi-cycle fifth-power unit among
// N_REQ requesters. Optional BUSY timeout enabled by POW5_SCHED_TIMEOUT_EN;
// without it BUSY waits for unit_ready indefinitely and err stays 0.
module pow5_sched
    import pow5_sched_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_n,
    output logic [N_REQ-1:0]       gnt,
    output logic                   unit_run,
    output logic [WIDTH-1:0]       unit_n,
    input  logic                   unit_ready,
    input  logic [WIDTH-1:0]       unit_result,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   err,
    output logic                   busy
);

    localparam int LW = $clog2(N_REQ);

    state_t          state;
    logic [LW-1:0]   last;
    logic [LW-1:0]   owner;
    logic            any;
    logic [N_REQ-1:0] pick;
    logic [LW-1:0]   pick_idx;
    logic [WIDTH-1:0] sel_n;

`ifdef POW5_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
`endif

    pow5_rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_pick (
        .req  (req),
        .last (last),
        .any  (any),
        .pick (pick)
    );

    // Encode the one-hot winner and mux its operand.
    always_comb begin
        pick_idx = '0;
        sel_n    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) begin
                pick_idx = LW'(i);
                sel_n    = req_n[i*WIDTH +: WIDTH];
            end
        end
    end

    // Control FSM; gnt/unit_run/done are one-cycle pulses, everything registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            last     <= LW'(N_REQ - 1);
            owner    <= '0;
            gnt      <= '0;
            unit_run <= 1'b0;
            unit_n   <= '0;
            done     <= '0;
            result   <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
`ifdef POW5_SCHED_TIMEOUT_EN
            tcnt     <= '0;
`endif
        end else begin
            gnt      <= '0;
            unit_run <= 1'b0;
            done     <= '0;
            case (state)
                IDLE: begin
                    // unit_ready here is a stale pulse and is dropped.
                    if (any) begin
                        gnt      <= pick;
                        unit_run <= 1'b1;
                        unit_n   <= sel_n;
                        owner    <= pick_idx;
                        last     <= pick_idx;
                        busy     <= 1'b1;
                        state    <= BUSY;
`ifdef POW5_SCHED_TIMEOUT_EN
                        tcnt     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (unit_ready) begin
                        done[owner] <= 1'b1;
                        result      <= unit_result;
                        err         <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
`ifdef POW5_SCHED_TIMEOUT_EN
                    // ready in the same cycle as the limit takes priority above.
                    else if (tcnt == TW'(TIMEOUT)) begin
                        done[owner] <= 1'b1;
                        result      <= '0;
                        err         <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
